// File: rtl/subtr_pkg.sv
// Shared constants and types for the subtractor result stage.
// Flag vector layout is {ovf, borrow, neg, zero}.
package subtr_pkg;

  localparam int SUBTR_W    = 4;

  localparam int FLG_ZERO   = 0;
  localparam int FLG_NEG    = 1;
  localparam int FLG_BORROW = 2;
  localparam int FLG_OVF    = 3;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/subtr_flag_gen.sv
// Combinational flag derivation from the subtractor sum and carry vector.
// The subtractor computes A + ~B + 1, so a missing carry-out means a borrow.
module subtr_flag_gen
  import subtr_pkg::*;
(
  input  logic [SUBTR_W-1:0] s,
  input  logic [SUBTR_W-1:0] c,
  output flags_t             flags
);

  // Only the top two carries matter for borrow and signed overflow.
  logic unused_low_carries;
  assign unused_low_carries = ^c[1:0];

  always_comb begin
    flags              = '0;
    flags[FLG_ZERO]    = (s == '0);
    flags[FLG_NEG]     = s[SUBTR_W-1];
    flags[FLG_BORROW]  = ~c[SUBTR_W-1];
    flags[FLG_OVF]     = c[SUBTR_W-1] ^ c[SUBTR_W-2];
  end

endmodule

// File: rtl/subtr_result_stage.sv
// Registered result stage: flags computed at push time, 2-entry FIFO, valid/ready out.
// Optional sticky overflow flag enabled by defining SUBTR_RES_STICKY_EN.
module subtr_result_stage
  import subtr_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SUBTR_W-1:0] s,
  input  logic [SUBTR_W-1:0] c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SUBTR_W-1:0] out_s,
  output flags_t             out_flags,
  output logic               sticky_ovf,
  input  logic               sticky_clr
);

  flags_t             in_flags;
  logic [SUBTR_W-1:0] s_q [2];
  flags_t             flags_q [2];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [1:0]         count_q;
  logic [1:0]         count_d;
  logic               push;
  logic               pop;

  subtr_flag_gen u_flag_gen (
    .s     (s),
    .c     (c),
    .flags (in_flags)
  );

  // Ready depends only on the registered count, never on out_ready.
  assign in_ready  = (count_q != 2'(DEPTH));
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q[gi]     <= '0;
        flags_q[gi] <= '0;
      end else if (push && (wr_ptr_q == 1'(gi))) begin
        s_q[gi]     <= s;
        flags_q[gi] <= in_flags;
      end
    end
  end

  assign out_s     = s_q[rd_ptr_q];
  assign out_flags = flags_q[rd_ptr_q];

`ifdef SUBTR_RES_STICKY_EN
  logic sticky_q;
  logic sticky_d;

  // A new overflow in the same cycle as a clear keeps the flag set.
  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr)                   sticky_d = 1'b0;
    if (push && in_flags[FLG_OVF])    sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign sticky_ovf = sticky_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_subtr_result_stage.sv
// Randomized self-checking bench for subtr_result_stage with a queue-based model.
// Honors SUBTR_RES_STICKY_EN for the sticky overflow expectation.
module tb_subtr_result_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       sticky_clr = 1'b0;
  logic [3:0] s = 4'd0;
  logic [3:0] c = 4'd0;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_s;
  logic [3:0] out_flags;
  logic       sticky_ovf;

  subtr_result_stage #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .s          (s),
    .c          (c),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_s      (out_s),
    .out_flags  (out_flags),
    .sticky_ovf (sticky_ovf),
    .sticky_clr (sticky_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] s;
    logic [3:0] f;
  } ent_t;

  ent_t mq[$];
  ent_t cur;
  bit   m_sticky = 1'b0;
  bit   chk_en = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Builds subtractor outputs for a-b and the expected entry from plain arithmetic.
  task automatic drive(input bit v, input int a, input int b);
    int carry;
    int t;
    int sa;
    int sb;
    int d;
    logic [3:0] so;
    logic [3:0] co;
    carry = 1;
    for (int i = 0; i < 4; i++) begin
      t = ((a >> i) & 1) + (((~b) >> i) & 1) + carry;
      so[i] = t[0];
      co[i] = t[1];
      carry = t >> 1;
    end
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    d  = sa - sb;
    cur.s    = 4'((a - b) & 15);
    cur.f[3] = (d < -8) || (d > 7);
    cur.f[2] = (a < b);
    cur.f[1] = (((a - b) & 8) != 0);
    cur.f[0] = (a == b);
    s = so;
    c = co;
    in_valid = v;
  endtask

  // Advance one clock with the currently driven inputs and update the model.
  task automatic step();
    bit push;
    bit pop;
    bit set;
    push = in_valid && (mq.size() < 2);
    pop  = out_ready && (mq.size() > 0);
    set  = push && cur.f[3];
    @(posedge clk);
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(cur);
`ifdef SUBTR_RES_STICKY_EN
    m_sticky = set ? 1'b1 : (sticky_clr ? 1'b0 : m_sticky);
`else
    m_sticky = 1'b0 & set;
`endif
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("out_valid", 8'(out_valid), 8'(mq.size() != 0));
      chk("in_ready", 8'(in_ready), 8'(mq.size() != 2));
      chk("sticky_ovf", 8'(sticky_ovf), 8'(m_sticky));
      if (mq.size() != 0) begin
        chk("out_s", 8'(out_s), 8'(mq[0].s));
        chk("out_flags", 8'(out_flags), 8'(mq[0].f));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 8'(out_valid), 8'd0);
    chk("rst_in_ready", 8'(in_ready), 8'd1);
    chk("rst_out_s", 8'(out_s), 8'd0);
    chk("rst_out_flags", 8'(out_flags), 8'd0);
    chk("rst_sticky", 8'(sticky_ovf), 8'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // 5-3, 3-5, 7-(-8) with literal expectations
    out_ready = 1'b1;
    drive(1, 5, 3); step();
    chk("lit_5m3_valid", 8'(out_valid), 8'd1);
    chk("lit_5m3_s", 8'(out_s), 8'd2);
    chk("lit_5m3_flags", 8'(out_flags), 8'b0000);
    drive(1, 3, 5); step();
    chk("lit_3m5_s", 8'(out_s), 8'b1110);
    chk("lit_3m5_flags", 8'(out_flags), 8'b0110);
    drive(1, 7, 8); step();
    chk("lit_ovf_s", 8'(out_s), 8'b1111);
    chk("lit_ovf_flags", 8'(out_flags), 8'b1110);
`ifdef SUBTR_RES_STICKY_EN
    chk("lit_sticky_set", 8'(sticky_ovf), 8'd1);
`else
    chk("lit_sticky_off", 8'(sticky_ovf), 8'd0);
`endif
    drive(0, 0, 0);
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    chk("lit_sticky_clr", 8'(sticky_ovf), 8'd0);
    step();

    // Backpressure: two accepted, third held until space frees up
    out_ready = 1'b0;
    drive(1, 1, 0); step();
    drive(1, 2, 0); step();
    chk("lit_full_in_ready", 8'(in_ready), 8'd0);
    drive(1, 3, 0); step();
    chk("lit_full_head", 8'(out_s), 8'd1);
    out_ready = 1'b1;
    step();
    chk("lit_drain1", 8'(out_s), 8'd2);
    chk("lit_drain1_ready", 8'(in_ready), 8'd1);
    step();
    chk("lit_drain2", 8'(out_s), 8'd3);
    drive(0, 0, 0); step();
    chk("lit_empty", 8'(out_valid), 8'd0);

    // count==1 with simultaneous push/pop across pointer wraps
    out_ready = 1'b0;
    drive(1, 9, 4); step();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1, 10 + k, 0); step();
      chk("lit_pp_s", 8'(out_s), 8'(10 + k));
      chk("lit_pp_ready", 8'(in_ready), 8'd1);
    end
    drive(0, 0, 0); step(); step();

    // Randomized traffic; upstream holds its input while not accepted
    for (int n = 0; n < 400; n++) begin
      if (!(in_valid && mq.size() == 2)) begin
        drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      end
      out_ready  = ($urandom_range(0, 2) != 0);
      sticky_clr = ($urandom_range(0, 7) == 0);
      step();
    end
    sticky_clr = 1'b0;

    // Asynchronous reset with two entries queued
    out_ready = 1'b0;
    drive(0, 0, 0); step(); step();
    drive(1, 4, 1); step();
    drive(1, 6, 2); step();
    drive(0, 0, 0);
    chk("lit_pre_rst_ready", 8'(in_ready), 8'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("lit_arst_valid", 8'(out_valid), 8'd0);
    chk("lit_arst_ready", 8'(in_ready), 8'd1);
    chk("lit_arst_s", 8'(out_s), 8'd0);
    chk("lit_arst_flags", 8'(out_flags), 8'd0);
    chk("lit_arst_sticky", 8'(sticky_ovf), 8'd0);
    mq.delete();
    m_sticky = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1, 12, 5); step();
    chk("lit_post_rst_s", 8'(out_s), 8'd7);
    drive(0, 0, 0); step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
